alu_exec_unit: RTL and testbench

Registered execute stage directly downstream of the ALU control decoder: it consumes the 3-bit ALU control code plus two operands and produces a registered result and zero flag. Arithmetic/logic codes complete in one cycle. The three code points the decoder leaves unused (100, 110, 111) are defined here as iterative shifts that take one cycle per bit. A valid/ready handshake on both sides lets the core stall while a shift is in flight.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_comb.sv | 28 ++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 tb/tb_alu_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the decoder and execute stage, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // ALU control codes; the three shift codes fill the decoder's unused points
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for the iterative (one bit per cycle) shift codes
  function automatic logic is_shift(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ADD/SUB/AND/OR/SLT datapath; shift codes produce zero here.
// Latency: purely combinational.
// Backpressure: none, no state.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] y
);

  // Select the arithmetic/logic result; ADD/SUB wrap, SLT is a signed compare
  always_comb begin
    y = '0;
    case (alu_control)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: one-cycle ALU ops plus bit-serial shifts (one cycle per bit).
// Latency: 1 edge after accept for ALU ops and zero shifts, N+1 edges for a shift by N.
// Backpressure: in_ready only in IDLE; DONE holds result until out_ready, then IDLE.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] comb_y;
  logic [WIDTH-1:0] shift_step;
  logic [SW-1:0]    shamt;

  assign shamt = src_b[SW-1:0];

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .a           (src_a),
    .b           (src_b),
    .alu_control (alu_control),
    .y           (comb_y)
  );

  // One-bit shift of the working register; SRA replicates the sign bit
  always_comb begin
    shift_step = shreg_q;
    case (op_q)
      ALU_SLL: shift_step = {shreg_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shift_step = {1'b0, shreg_q[WIDTH-1:1]};
      ALU_SRA: shift_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shift_step = shreg_q;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, hold in DONE until taken
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = alu_control;
          if (is_shift(alu_control)) begin
            if (shamt == '0) begin
              result_d = src_a;
              zero_d   = (src_a == '0);
              state_d  = ST_DONE;
            end else begin
              shreg_d = src_a;
              cnt_d   = shamt;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = comb_y;
            zero_d   = (comb_y == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = shift_step;
        cnt_d   = cnt_q - SW'(1);
        // Last step: publish the final value directly so DONE follows immediately
        if (cnt_q == SW'(1)) begin
          result_d = shift_step;
          zero_d   = (shift_step == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  // Handshake and status decoded from the state register only
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a behavioural arithmetic model.
// Latency: checks 1-edge ALU latency and N+1-edge shift latency.
// Backpressure: exercises out_ready holds and reset during a shift.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [2:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain arithmetic per control code
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100: return a << sh;
      3'b110: return a >> sh;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic [2:0] c);
    int sh;
    sh = int'(b[4:0]);
    if ((c == 3'b100 || c == 3'b110 || c == 3'b111) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // Present one op, accept it, then wait (bounded) until out_valid; sampled 1 time unit after edges
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                        output int lat, output int busy_cyc, output bit timed_out);
    src_a = a; src_b = b; alu_control = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_cyc = 0; timed_out = 1'b0;
    while (!out_valid) begin
      if (busy) busy_cyc++;
      if (lat >= 100) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; alu_control = 3'b000;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (result !== 32'd0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: result=%h zero=%b, want 0 0", result, zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat, bc; bit to;
    run_op(32'h7FFF_FFFF, 32'h1, 3'b000, lat, bc, to);
    checks++;
    if (to || lat !== 1) begin
      failures++;
      $display("FAIL add_latency: got %0d (timeout=%0d), want 1", lat, to);
    end
    checks++;
    if (result !== 32'h8000_0000 || zero !== 1'b0) begin
      failures++;
      $display("FAIL add_result: result=%h zero=%b, want 80000000 0", result, zero);
    end
    finish_op();
  endtask

  task automatic test_sub();
    int lat, bc; bit to;
    run_op(32'd5, 32'd5, 3'b001, lat, bc, to);
    checks++;
    if (to || result !== 32'd0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_zero: result=%h zero=%b timeout=%0d, want 0 1", result, zero, to);
    end
    finish_op();
  endtask

  task automatic test_slt();
    int lat, bc; bit to;
    run_op(32'hFFFF_FFFF, 32'd1, 3'b101, lat, bc, to);
    checks++;
    if (to || result !== 32'd1 || zero !== 1'b0) begin
      failures++;
      $display("FAIL slt_neg: result=%h zero=%b timeout=%0d, want 1 0", result, zero, to);
    end
    finish_op();
  endtask

  task automatic test_sra31();
    int lat, bc; bit to;
    run_op(32'h8000_0000, 32'd31, 3'b111, lat, bc, to);
    checks++;
    if (to || lat !== 32) begin
      failures++;
      $display("FAIL sra31_latency: got %0d (timeout=%0d), want 32", lat, to);
    end
    checks++;
    if (bc !== 31) begin
      failures++;
      $display("FAIL sra31_busy: got %0d busy cycles, want 31", bc);
    end
    checks++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      failures++;
      $display("FAIL sra31_result: result=%h zero=%b, want ffffffff 0", result, zero);
    end
    finish_op();
  endtask

  task automatic test_srl0();
    int lat, bc; bit to;
    run_op(32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'b110, lat, bc, to);
    checks++;
    if (to || lat !== 1 || bc !== 0) begin
      failures++;
      $display("FAIL srl0_latency: lat=%0d busy=%0d timeout=%0d, want 1 0", lat, bc, to);
    end
    checks++;
    if (result !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL srl0_result: result=%h, want deadbeef", result);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat, bc; bit to;
    out_ready = 1'b0;
    run_op(32'h0F0F_0000, 32'h0000_00F0, 3'b011, lat, bc, to);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (to || result !== 32'h0F0F_00F0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: result=%h out_valid=%b in_ready=%b, want 0f0f00f0 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    finish_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midshift();
    int lat, bc; bit to;
    src_a = 32'h1234_5678; src_b = 32'd20; alu_control = 3'b100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midshift_busy: busy=%b, want 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midshift_reset: out_valid=%b result=%h in_ready=%b busy=%b, want 0 0 1 0",
               out_valid, result, in_ready, busy);
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd3, 32'd4, 3'b000, lat, bc, to);
    checks++;
    if (to || lat !== 1 || result !== 32'd7) begin
      failures++;
      $display("FAIL midshift_next: result=%h lat=%0d timeout=%0d, want 7 1", result, lat, to);
    end
    finish_op();
  endtask

  task automatic test_random();
    int lat, bc, hold, exp_lat; bit to;
    logic [W-1:0] a, b, exp;
    logic [2:0] c;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      if (n % 5 == 0) a = b;
      exp = model(a, b, c);
      exp_lat = model_lat(b, c);
      hold = $urandom_range(0, 2);
      out_ready = (hold == 0);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: in_ready=%b, want 1", n, in_ready);
      end
      run_op(a, b, c, lat, bc, to);
      checks++;
      if (to || lat !== exp_lat || bc !== exp_lat - 1) begin
        failures++;
        $display("FAIL rnd_timing[%0d]: op=%0d lat=%0d busy=%0d timeout=%0d, want lat %0d busy %0d",
                 n, c, lat, bc, to, exp_lat, exp_lat - 1);
      end
      checks++;
      if (result !== exp || zero !== (exp == '0)) begin
        failures++;
        $display("FAIL rnd_result[%0d]: op=%0d a=%h b=%h result=%h zero=%b, want %h %b",
                 n, c, a, b, result, zero, exp, (exp == '0));
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (result !== exp || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL rnd_hold[%0d]: result=%h out_valid=%b, want %h 1", n, result, out_valid, exp);
        end
      end
      if (hold != 0) finish_op();
      else begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_sra31();
    test_srl0();
    test_backpressure();
    test_reset_midshift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
